// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
// parking_pkg
// Gate arbiter FSM state encoding shared with display control.
// Revision: 1.0 - initial release
// ============================================================================
package parking_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE       = 3'd0;
   localparam state_t ST_OPENING    = 3'd1;
   localparam state_t ST_WAIT_ENTER = 3'd2;
   localparam state_t ST_WAIT_CLEAR = 3'd3;
   localparam state_t ST_CLOSING    = 3'd4;

endpackage
`default_nettype wire

// File: rtl/gate_timeout_timer.sv
`default_nettype none
// ============================================================================
// gate_timeout_timer
// Clear/enable counter that saturates at Max and flags its terminal count.
// Revision: 1.0 - initial release
// ============================================================================
module gate_timeout_timer #(
   parameter int Max   = 7,
   parameter int Width = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   logic [Width-1:0] r_count;

   assign terminal = (r_count == Width'(Max));

   // Count up while enabled, hold at Max; clear has priority over counting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (enable && !terminal) begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/parking_gate_arbiter.sv
`default_nettype none
// ============================================================================
// parking_gate_arbiter
// Round-robin arbitration of the shared barrier gate between entry and exit
// lanes, gate open/pass/close sequencing and occupancy bookkeeping.
// Revision: 1.0 - initial release
// ============================================================================
module parking_gate_arbiter
   import parking_pkg::*;
#(
   parameter int Capacity    = 4,
   parameter int CountWidth  = 3,
   parameter int PassTimeout = 50_000_000,
   parameter int TimerWidth  = 26
) (
   input  logic                  Clk,
   input  logic                  ResetN,
   input  logic                  EntryReq,
   input  logic                  ExitReq,
   input  logic                  GateOpened,
   input  logic                  GateClosed,
   input  logic                  PassSensor,
   output logic                  EntryGrant,
   output logic                  ExitGrant,
   output logic                  GateOpenCmd,
   output logic                  GateCloseCmd,
   output logic [CountWidth-1:0] Occupancy,
   output logic                  Full,
   output logic                  Empty,
   output logic                  EntryDenied,
   output logic                  TimeoutFlag,
   output logic [2:0]            State
);

   localparam logic [CountWidth-1:0] c_capacity = CountWidth'(Capacity);

   state_t                r_state;
   state_t                w_next_state;
   logic                  r_serve_exit;
   logic                  r_last_exit;
   logic                  r_deny_lvl;
   logic                  w_opened;
   logic                  w_closed;
   logic                  w_elig_entry;
   logic                  w_elig_exit;
   logic                  w_grant;
   logic                  w_grant_exit;
   logic                  w_serve_exit_nxt;
   logic                  w_timer_en;
   logic                  w_timer_term;
   logic                  w_timeout_hit;
   logic                  w_commit;
   logic                  w_deny_lvl;
   logic                  w_open_nxt;
   logic                  w_close_nxt;
   logic [CountWidth-1:0] w_occ_nxt;

   // A stuck pair of limit switches means neither open nor closed.
   assign w_opened = GateOpened & ~GateClosed;
   assign w_closed = GateClosed & ~GateOpened;

   // Arbitration: the lane not served last wins a tie.
   assign w_elig_entry     = EntryReq & ~Full;
   assign w_elig_exit      = ExitReq;
   assign w_grant          = (r_state == ST_IDLE) & (w_elig_entry | w_elig_exit);
   assign w_grant_exit     = w_elig_exit & (~w_elig_entry | ~r_last_exit);
   assign w_serve_exit_nxt = w_grant ? w_grant_exit : r_serve_exit;

   assign w_timer_en = (r_state == ST_OPENING) | (r_state == ST_WAIT_ENTER);
   assign w_deny_lvl = (r_state == ST_IDLE) & EntryReq & Full;

   assign State = r_state;

   gate_timeout_timer #(
      .Max   (PassTimeout - 1),
      .Width (TimerWidth)
   ) u_timer (
      .clk      (Clk),
      .rst_n    (ResetN),
      .clear    (w_grant),
      .enable   (w_timer_en),
      .terminal (w_timer_term)
   );

   // State register plus the served-lane and round-robin history.
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         r_state      <= ST_IDLE;
         r_serve_exit <= 1'b0;
         r_last_exit  <= 1'b1;
      end else begin
         r_state      <= w_next_state;
         r_serve_exit <= w_serve_exit_nxt;
         if ((r_state == ST_CLOSING) && (w_next_state == ST_IDLE)) begin
            r_last_exit <= r_serve_exit;
         end
      end
   end

   // Next-state logic; the awaited sensor event beats a same-cycle timeout.
   always_comb begin
      w_next_state  = r_state;
      w_timeout_hit = 1'b0;
      w_commit      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_grant) w_next_state = ST_OPENING;
         end
         ST_OPENING: begin
            if (w_opened) begin
               w_next_state = ST_WAIT_ENTER;
            end else if (w_timer_term) begin
               w_next_state  = ST_CLOSING;
               w_timeout_hit = 1'b1;
            end
         end
         ST_WAIT_ENTER: begin
            if (PassSensor) begin
               w_next_state = ST_WAIT_CLEAR;
            end else if (w_timer_term) begin
               w_next_state  = ST_CLOSING;
               w_timeout_hit = 1'b1;
            end
         end
         ST_WAIT_CLEAR: begin
            if (!PassSensor) begin
               w_next_state = ST_CLOSING;
               w_commit     = 1'b1;
            end
         end
         ST_CLOSING: begin
            if (w_closed && !PassSensor) w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs, derived from the upcoming state.
   always_comb begin
      w_open_nxt  = 1'b0;
      w_close_nxt = 1'b0;
      case (w_next_state)
         ST_OPENING, ST_WAIT_ENTER, ST_WAIT_CLEAR: w_open_nxt = 1'b1;
         ST_CLOSING: begin
            w_open_nxt  = PassSensor;
            w_close_nxt = ~PassSensor;
         end
         default: w_close_nxt = ~GateClosed;
      endcase
      w_occ_nxt = Occupancy;
      if (w_commit) begin
         if (r_serve_exit) begin
            if (Occupancy != '0) w_occ_nxt = Occupancy - 1'b1;
         end else begin
            if (Occupancy != c_capacity) w_occ_nxt = Occupancy + 1'b1;
         end
      end
   end

   // Output registers: grants, motor commands, count flags and pulses.
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         EntryGrant   <= 1'b0;
         ExitGrant    <= 1'b0;
         GateOpenCmd  <= 1'b0;
         GateCloseCmd <= 1'b0;
         Occupancy    <= '0;
         Full         <= 1'b0;
         Empty        <= 1'b1;
         EntryDenied  <= 1'b0;
         TimeoutFlag  <= 1'b0;
         r_deny_lvl   <= 1'b0;
      end else begin
         EntryGrant   <= (w_next_state != ST_IDLE) & ~w_serve_exit_nxt;
         ExitGrant    <= (w_next_state != ST_IDLE) &  w_serve_exit_nxt;
         GateOpenCmd  <= w_open_nxt;
         GateCloseCmd <= w_close_nxt;
         Occupancy    <= w_occ_nxt;
         Full         <= (w_occ_nxt == c_capacity);
         Empty        <= (w_occ_nxt == '0);
         EntryDenied  <= w_deny_lvl & ~r_deny_lvl;
         TimeoutFlag  <= w_timeout_hit;
         r_deny_lvl   <= w_deny_lvl;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_parking_gate_arbiter.sv
`default_nettype none
// ============================================================================
// tb_parking_gate_arbiter
// Directed and randomized bench for the parking gate arbiter, checked against
// a transaction-level model of occupancy and round-robin lane selection.
// Revision: 1.0 - initial release
// ============================================================================
module tb_parking_gate_arbiter;
   import parking_pkg::*;

   localparam int CAP = 2;
   localparam int CW  = 3;
   localparam int PT  = 8;
   localparam int TW  = 4;

   logic          Clk        = 1'b0;
   logic          ResetN     = 1'b0;
   logic          EntryReq   = 1'b0;
   logic          ExitReq    = 1'b0;
   logic          GateOpened = 1'b0;
   logic          GateClosed = 1'b1;
   logic          PassSensor = 1'b0;
   logic          EntryGrant, ExitGrant, GateOpenCmd, GateCloseCmd;
   logic [CW-1:0] Occupancy;
   logic          Full, Empty, EntryDenied, TimeoutFlag;
   logic [2:0]    State;

   int errors = 0;
   int checks = 0;
   int occ_m  = 0;
   bit last_exit_m = 1'b1;

   always #5 Clk = ~Clk;

   parking_gate_arbiter #(
      .Capacity(CAP), .CountWidth(CW), .PassTimeout(PT), .TimerWidth(TW)
   ) dut (
      .Clk(Clk), .ResetN(ResetN), .EntryReq(EntryReq), .ExitReq(ExitReq),
      .GateOpened(GateOpened), .GateClosed(GateClosed), .PassSensor(PassSensor),
      .EntryGrant(EntryGrant), .ExitGrant(ExitGrant), .GateOpenCmd(GateOpenCmd),
      .GateCloseCmd(GateCloseCmd), .Occupancy(Occupancy), .Full(Full), .Empty(Empty),
      .EntryDenied(EntryDenied), .TimeoutFlag(TimeoutFlag), .State(State)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk_counts(input string tag);
      chkv({tag, "_occ"}, 32'(Occupancy), 32'(occ_m));
      chk1({tag, "_full"}, Full, occ_m == CAP);
      chk1({tag, "_empty"}, Empty, occ_m == 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chkv({tag, "_state"}, 32'(State), 32'(ST_IDLE));
      chk1({tag, "_egrant"}, EntryGrant, 1'b0);
      chk1({tag, "_xgrant"}, ExitGrant, 1'b0);
      chk1({tag, "_open"}, GateOpenCmd, 1'b0);
      chk1({tag, "_close"}, GateCloseCmd, 1'b0);
      chkv({tag, "_occ"}, 32'(Occupancy), 32'd0);
      chk1({tag, "_full"}, Full, 1'b0);
      chk1({tag, "_empty"}, Empty, 1'b1);
      chk1({tag, "_denied"}, EntryDenied, 1'b0);
      chk1({tag, "_timeout"}, TimeoutFlag, 1'b0);
   endtask

   task automatic do_reset();
      ResetN = 1'b0; EntryReq = 1'b0; ExitReq = 1'b0;
      GateOpened = 1'b0; GateClosed = 1'b1; PassSensor = 1'b0;
      step(); step();
      chk_reset_vals("rst");
      ResetN = 1'b1; occ_m = 0; last_exit_m = 1'b1;
      step();
      chk1("rst_closed_idle_close", GateCloseCmd, 1'b0);
   endtask

   // One complete request/service transaction; the model decides the winner.
   task automatic serve(input bit ereq, input bit xreq, input int open_dly,
                        input int clear_len, input int obst, input int tail);
      bit el_e, el_x, gx;
      el_e = ereq && (occ_m < CAP);
      el_x = xreq;
      chk1("grant_before_req", EntryGrant | ExitGrant, 1'b0);
      EntryReq = ereq; ExitReq = xreq;
      if (!el_e && !el_x) begin
         step();
         chkv("no_grant_state", 32'(State), 32'(ST_IDLE));
         chk1("no_grant", EntryGrant | ExitGrant, 1'b0);
         chk1("denied_pulse", EntryDenied, ereq);
         step();
         chk1("denied_once", EntryDenied, 1'b0);
         EntryReq = 1'b0; ExitReq = 1'b0;
         step();
         return;
      end
      gx = el_x && (!el_e || !last_exit_m);
      step();
      chkv("state_opening", 32'(State), 32'(ST_OPENING));
      chk1("entry_grant", EntryGrant, !gx);
      chk1("exit_grant", ExitGrant, gx);
      chk1("open_cmd", GateOpenCmd, 1'b1);
      chk1("close_cmd_opening", GateCloseCmd, 1'b0);
      EntryReq = 1'b0; ExitReq = 1'b0; GateClosed = 1'b0;
      repeat (open_dly) begin
         step();
         chkv("hold_opening", 32'(State), 32'(ST_OPENING));
      end
      GateOpened = 1'b1;
      step();
      chkv("state_wait_enter", 32'(State), 32'(ST_WAIT_ENTER));
      PassSensor = 1'b1;
      step();
      chkv("state_wait_clear", 32'(State), 32'(ST_WAIT_CLEAR));
      repeat (clear_len) begin
         step();
         chkv("hold_wait_clear", 32'(State), 32'(ST_WAIT_CLEAR));
         chk1("open_wait_clear", GateOpenCmd, 1'b1);
      end
      PassSensor = 1'b0;
      step();
      chkv("state_closing", 32'(State), 32'(ST_CLOSING));
      chk1("close_cmd_closing", GateCloseCmd, 1'b1);
      chk1("open_cmd_closing", GateOpenCmd, 1'b0);
      if (gx) occ_m = (occ_m > 0) ? occ_m - 1 : 0;
      else    occ_m = (occ_m < CAP) ? occ_m + 1 : CAP;
      GateOpened = 1'b0;
      if (obst > 0) begin
         PassSensor = 1'b1;
         repeat (obst) begin
            step();
            chk1("obst_open", GateOpenCmd, 1'b1);
            chk1("obst_close", GateCloseCmd, 1'b0);
            chkv("obst_state", 32'(State), 32'(ST_CLOSING));
         end
         PassSensor = 1'b0;
         step();
         chk1("resume_close", GateCloseCmd, 1'b1);
         chk1("resume_open", GateOpenCmd, 1'b0);
      end
      repeat (tail) begin
         step();
         chkv("hold_closing", 32'(State), 32'(ST_CLOSING));
      end
      GateClosed = 1'b1;
      step();
      chkv("back_idle", 32'(State), 32'(ST_IDLE));
      chk1("grant_dropped", EntryGrant | ExitGrant, 1'b0);
      chk1("idle_close_closed", GateCloseCmd, 1'b0);
      chk_counts("after_service");
      last_exit_m = gx;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pulses;

      // Reset state and single entry.
      do_reset();
      serve(1'b1, 1'b0, 1, 1, 0, 1);

      // Simultaneous requests twice: entry then exit.
      do_reset();
      serve(1'b1, 1'b1, 0, 0, 0, 0);
      serve(1'b1, 1'b1, 2, 1, 0, 1);

      // Fill the lot, hold a refused entry, then let an exit through.
      do_reset();
      serve(1'b1, 1'b0, 0, 0, 0, 0);
      serve(1'b1, 1'b0, 1, 0, 0, 0);
      chk1("full_flag", Full, 1'b1);
      EntryReq = 1'b1;
      pulses = 0;
      repeat (5) begin
         step();
         if (EntryDenied) pulses++;
         chk1("full_no_grant", EntryGrant | ExitGrant, 1'b0);
      end
      chkv("denied_pulse_count", 32'(pulses), 32'd1);
      EntryReq = 1'b0;
      step();
      serve(1'b0, 1'b1, 1, 0, 0, 0);
      chkv("occ_after_exit", 32'(Occupancy), 32'd1);

      // Timeout: gate opens but no vehicle arrives.
      EntryReq = 1'b1;
      step();
      chk1("to_grant", EntryGrant, 1'b1);
      EntryReq = 1'b0; GateClosed = 1'b0;
      for (int k = 1; k <= PT; k++) begin
         if (k == 2) GateOpened = 1'b1;
         step();
         if (k < PT) chk1("to_early", TimeoutFlag, 1'b0);
      end
      chk1("to_pulse", TimeoutFlag, 1'b1);
      chkv("to_state", 32'(State), 32'(ST_CLOSING));
      step();
      chk1("to_single", TimeoutFlag, 1'b0);
      GateOpened = 1'b0; GateClosed = 1'b1;
      step();
      chkv("to_idle", 32'(State), 32'(ST_IDLE));
      chk_counts("to_count");
      last_exit_m = 1'b0;

      // Obstruction while closing; counted once.
      serve(1'b1, 1'b0, 0, 1, 3, 1);

      // Reset in the middle of a service.
      do_reset();
      serve(1'b1, 1'b0, 0, 0, 0, 0);
      EntryReq = 1'b1;
      step();
      EntryReq = 1'b0; GateClosed = 1'b0; GateOpened = 1'b1;
      step();
      PassSensor = 1'b1;
      step();
      chkv("mid_wait_clear", 32'(State), 32'(ST_WAIT_CLEAR));
      chkv("mid_occ", 32'(Occupancy), 32'd1);
      #3 ResetN = 1'b0;
      #1 chk_reset_vals("async_rst");
      GateOpened = 1'b0; PassSensor = 1'b0;
      step();
      ResetN = 1'b1; occ_m = 0; last_exit_m = 1'b1;
      step();
      chk1("post_rst_close", GateCloseCmd, 1'b1);
      chkv("post_rst_state", 32'(State), 32'(ST_IDLE));
      chk_counts("post_rst");
      GateClosed = 1'b1;
      step();
      chk1("post_rst_closed", GateCloseCmd, 1'b0);

      // Randomized transactions.
      for (int n = 0; n < 30; n++) begin
         bit er, xr;
         int ob;
         er = 1'($urandom_range(0, 1));
         xr = 1'($urandom_range(0, 1));
         ob = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         serve(er, xr, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               ob, int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/parking_gate_arbiter.md
# parking_gate_arbiter

Shares the single barrier gate of the parking lot between the entry lane (request raised once the password check accepts a driver) and the exit lane. It arbitrates the two requesters round-robin, sequences the gate open, pass and close steps, and owns the occupancy count. It sits between the password-check and sensor logic and the gate motor driver; its `Occupancy`, `Full` and `State` outputs feed display control.

## Interface
- `Capacity`, 4: number of spots; `Full` when `Occupancy == Capacity`.
- `CountWidth`, 3: width of `Occupancy`; must hold `Capacity`.
- `PassTimeout`, 50_000_000: cycles allowed from grant to vehicle entering the gate zone.
- `TimerWidth`, 26: width of the timeout counter; must hold `PassTimeout-1`.

Ports:
- `Clk` in 1: system clock; one clock domain.
- `ResetN` in 1: reset, asynchronous, active-low.
- `EntryReq` in 1: level; held by the requester until `EntryGrant`.
- `ExitReq` in 1: level; held by the requester until `ExitGrant`.
- `GateOpened` in 1: open limit switch.
- `GateClosed` in 1: closed limit switch.
- `PassSensor` in 1: high while a vehicle is under the gate.
- `EntryGrant` out 1: high for the whole entry service.
- `ExitGrant` out 1: high for the whole exit service.
- `GateOpenCmd` out 1: motor open command.
- `GateCloseCmd` out 1: motor close command.
- `Occupancy` out CountWidth: occupied spots.
- `Full` out 1: `Occupancy == Capacity`.
- `Empty` out 1: `Occupancy == 0`.
- `EntryDenied` out 1: one-cycle pulse.
- `TimeoutFlag` out 1: one-cycle pulse.
- `State` out 3: FSM state code.

## Operation
- FSM states: IDLE=0, OPENING=1, WAIT_ENTER=2, WAIT_CLEAR=3, CLOSING=4. Codes 5–7 are unreachable and recover to IDLE.
- **IDLE**
  - Eligible requests are `ExitReq`, and `EntryReq & ~Full`.
  - One eligible request: grant it and go to OPENING.
  - Both eligible: grant the lane not served last (`LastExit` flag; its reset value makes entry win first).
  - `GateCloseCmd = ~GateClosed`, so the gate closes after reset. `GateOpenCmd = 0`.
- **OPENING**: `GateOpenCmd = 1`. On `GateOpened` go to WAIT_ENTER.
- **WAIT_ENTER**: `GateOpenCmd = 1`. On `PassSensor` going high go to WAIT_CLEAR.
- **WAIT_CLEAR**: `GateOpenCmd = 1`. On `PassSensor` going low, commit the count and go to CLOSING.
- **CLOSING**
  - `GateCloseCmd = ~PassSensor`. `GateOpenCmd = PassSensor`, which is the obstruction hold; it causes no recount.
  - On `GateClosed & ~PassSensor`: drop the grant, update `LastExit`, go to IDLE.
- **Timeout**
  - The timer is cleared when a grant is issued and counts in OPENING and WAIT_ENTER.
  - When it reaches `PassTimeout-1`: pulse `TimeoutFlag`, go to CLOSING, no count change.
- **Count commit**
  - Entry: +1, saturating at `Capacity`.
  - Exit: −1, saturating at 0; exit is still granted when `Empty`.
- **EntryDenied**: pulses on the rising edge of `EntryReq & Full`, sampled in IDLE. It pulses once per assertion, not every cycle.
- Requests arriving during a service wait; there is no queue beyond the held request levels.
- Grants are mutually exclusive and are never both high.

## Timing
- **Output registration**
  - All outputs are registered.
  - The grant and `GateOpenCmd` rise 1 cycle after the sampled request edge.
  - `State` tracks the FSM register.
- `Occupancy`, `Full` and `Empty` update on the cycle after the WAIT_CLEAR→CLOSING transition.
- **Reset values**: state IDLE, both grants 0, both gate commands 0, `Occupancy` 0, `Full` 0, `Empty` 1, pulses 0, timer 0, `LastExit` 1.
- **Reset mid-service**: the service is abandoned and the count is not changed by the abandoned service. After reset the IDLE close rule applies.
- **Same-cycle conflicts**
  - Timeout and the awaited sensor event in the same cycle: the sensor event wins.
  - Both limit switches high at once: treat as not opened and not closed (hold the state).

## Structure
- Shared package `parking_pkg` holds the state encoding constants (`ST_IDLE` … `ST_CLOSING`, 3-bit). `State` and display control both use them.
- One sub-module, `gate_timeout_timer`: clear/enable/terminal-count counter with parameter `Max`.

## Test plan
Simulation parameters: `PassTimeout` = 8, `Capacity` = 2.

1. **Single entry**: reset, then `EntryReq`, `GateOpened`, `PassSensor` 1→0, `GateClosed`.
   - `EntryGrant` rises 1 cycle after `EntryReq`.
   - State sequence is 1,2,3,4,0; `Occupancy` = 1.
2. **Simultaneous requests**: `EntryReq` and `ExitReq` together, twice in a row.
   - First grant goes to entry, second to exit.
   - `Occupancy` goes 0→1→0.
3. **Full**: two entries complete, then `EntryReq` held for 5 cycles.
   - `Full` = 1; `EntryDenied` pulses exactly once; no grant.
   - A following `ExitReq` is granted; `Occupancy` = 1.
4. **Timeout**: grant issued, `GateOpened` rises, `PassSensor` stays 0.
   - `TimeoutFlag` pulses 8 cycles after the grant; state moves to 4.
   - `Occupancy` is unchanged.
5. **Obstruction**: in CLOSING, `PassSensor` = 1 for 3 cycles.
   - `GateCloseCmd` = 0 and `GateOpenCmd` = 1 during those cycles, then closing resumes.
   - Count incremented only once.
6. **Reset mid-service**: `ResetN` low in WAIT_CLEAR with `Occupancy` = 1.
   - All outputs take their reset values asynchronously.
   - After release, `GateCloseCmd` = 1 while `GateClosed` = 0.
